// File: rtl/dp_ram_fifo_ctrl_if.sv
// Valid/ready push and pop bundle for the dp_ram FIFO controller.
// The master side feeds pushes and consumes pops; the slave side is the FIFO.
interface dp_ram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/dp_ram_fifo_ctrl.sv
// FIFO controller driving a dual-port RAM: port A writes, port B reads.
// A 2-entry skid buffer hides the RAM's one-cycle registered read latency.
module dp_ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  dp_ram_fifo_ctrl_if.slave     bus,
  output logic                  ram_wrA_o,
  output logic [ADDR_WIDTH-1:0] ram_addrA_o,
  output logic [DATA_WIDTH-1:0] ram_dataA_o,
  output logic                  ram_wrB_o,
  output logic [ADDR_WIDTH-1:0] ram_addrB_o,
  input  logic [DATA_WIDTH-1:0] ram_dataB_i,
  output logic [ADDR_WIDTH+1:0] level_o
);
  localparam logic [ADDR_WIDTH:0] FULL =
    {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [1:0]            ob_cnt_q, ob_cnt_d;
  logic [DATA_WIDTH-1:0] ob0_q, ob0_d;
  logic [DATA_WIDTH-1:0] ob1_q, ob1_d;

  logic       push;
  logic       pop;
  logic       issue;
  logic [2:0] inflight;

  assign bus.in_ready  = (ram_cnt_q != FULL);
  assign bus.out_valid = (ob_cnt_q != 2'd0);
  assign bus.out_data  = ob0_q;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Words already owned by the skid buffer after this cycle's pop
  assign inflight = {1'b0, ob_cnt_q}
                  + {2'b00, rd_pend_q}
                  - {2'b00, pop};
  assign issue = (ram_cnt_q != '0)
              && (inflight <= 3'd1);

  assign ram_wrA_o   = push;
  assign ram_addrA_o = wr_ptr_q;
  assign ram_dataA_o = bus.in_data;
  assign ram_wrB_o   = 1'b0;
  assign ram_addrB_o = rd_ptr_q;

  assign level_o = {1'b0, ram_cnt_q}
                 + {{(ADDR_WIDTH+1){1'b0}}, rd_pend_q}
                 + {{ADDR_WIDTH{1'b0}}, ob_cnt_q};

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q;
    rd_pend_d = 1'b0;
    ob_cnt_d  = ob_cnt_q;
    ob0_d     = ob0_q;
    ob1_d     = ob1_q;
    if (clr_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      ram_cnt_d = '0;
      ob_cnt_d  = 2'd0;
      ob0_d     = '0;
      ob1_d     = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (issue) rd_ptr_d = rd_ptr_q + 1'b1;
      rd_pend_d = issue;
      ram_cnt_d = ram_cnt_q
                + {{ADDR_WIDTH{1'b0}}, push}
                - {{ADDR_WIDTH{1'b0}}, issue};
      unique case (1'b1)
        pop && rd_pend_q: begin
          if (ob_cnt_q == 2'd2) begin
            ob0_d = ob1_q;
            ob1_d = ram_dataB_i;
          end else begin
            ob0_d = ram_dataB_i;
          end
        end
        pop && !rd_pend_q: begin
          ob0_d    = ob1_q;
          ob_cnt_d = ob_cnt_q - 2'd1;
        end
        !pop && rd_pend_q: begin
          if (ob_cnt_q == 2'd0) ob0_d = ram_dataB_i;
          else                  ob1_d = ram_dataB_i;
          ob_cnt_d = ob_cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      ob_cnt_q  <= 2'd0;
      ob0_q     <= '0;
      ob1_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      rd_pend_q <= rd_pend_d;
      ob_cnt_q  <= ob_cnt_d;
      ob0_q     <= ob0_d;
      ob1_q     <= ob1_d;
    end
  end
endmodule
